// File: rtl/dma_rd_unpacker.sv
// -----------------------------------------------------------------------------
// dma_rd_unpacker
//
// Read-side width converter between the DMA read FIFO and the miner's host
// data port. Whole cache lines are popped from a show-ahead FIFO into a
// two-slot line buffer. They are then handed out as a stream of narrower words,
// least-significant word first. Lines and words are counted against a
// software-supplied line count, and completion is flagged when the last word
// of the last line has been accepted.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   one-cycle pulse; latches line_count (ignored while busy)
//   line_count   in   [SIZE_WIDTH]  number of lines to move
//   dma_empty    in   DMA read FIFO empty; dma_rd_data valid while low
//   dma_rd_data  in   [LINE_WIDTH]  head line of the DMA read FIFO
//   dma_rd_en    out  pop strobe; the head line is captured in the same cycle
//   word_out     out  [WORD_WIDTH]  current output word
//   word_valid   out  word_out is valid
//   word_ready   in   consumer accepts word_out
//   word_last    out  final word of the final line
//   busy         out  transfer in progress
//   done         out  transfer finished; held until the next accepted start
//
// Handshake: a word moves on every rising edge where word_valid && word_ready.
// Once word_valid is raised, it stays high and word_out/word_last stay frozen
// until that transfer happens. Only reset can drop word_valid early.
// dma_rd_en depends only on registered state, dma_empty and rst_n, so there is
// no combinational path from word_ready.
// -----------------------------------------------------------------------------
module dma_rd_unpacker #(
  parameter int LINE_WIDTH = 512,
  parameter int WORD_WIDTH = 32,
  parameter int SIZE_WIDTH = 43
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] line_count,
  input  logic                  dma_empty,
  input  logic [LINE_WIDTH-1:0] dma_rd_data,
  output logic                  dma_rd_en,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  word_last,
  output logic                  busy,
  output logic                  done
);

  // Words per line and the width of the word index within a line.
  localparam int WPL   = LINE_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(WPL - 1);
  localparam logic [SIZE_WIDTH-1:0] ONE_LINE = SIZE_WIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q,         state_d;
  logic [SIZE_WIDTH-1:0] total_q,         total_d;
  logic [SIZE_WIDTH-1:0] lines_fetched_q, lines_fetched_d;
  logic [SIZE_WIDTH-1:0] lines_done_q,    lines_done_d;
  logic [IDX_W-1:0]      idx_q,           idx_d;
  logic [1:0]            occ_q,           occ_d;
  logic                  head_q,          head_d;
  logic                  tail_q,          tail_d;
  logic [LINE_WIDTH-1:0] slot0_q,         slot0_d;
  logic [LINE_WIDTH-1:0] slot1_q,         slot1_d;

  // ---------------------------------------------------------------------------
  // Datapath and status decode
  // ---------------------------------------------------------------------------
  logic                  in_run;
  logic                  in_done;
  logic                  buf_full;
  logic                  more_to_fetch;
  logic                  pop;
  logic                  at_last_word;
  logic                  on_final_line;
  logic                  xfer;
  logic                  line_free;
  logic [LINE_WIDTH-1:0] head_line;
  logic [WORD_WIDTH-1:0] head_words [WPL];

  assign in_run        = (state_q == ST_RUN);
  assign in_done       = (state_q == ST_DONE);
  assign buf_full      = (occ_q == 2'd2);
  assign more_to_fetch = (lines_fetched_q < total_q);

  // rst_n is included so no pop can be issued while reset is asserted, even
  // for the cycle before the registered state clears.
  assign pop = in_run && !dma_empty && !buf_full && more_to_fetch && rst_n;

  assign head_line = head_q ? slot1_q : slot0_q;

  for (genvar k = 0; k < WPL; k++) begin : g_words
    assign head_words[k] = head_line[k*WORD_WIDTH +: WORD_WIDTH];
  end

  assign at_last_word  = (idx_q == IDX_LAST);
  // total_q is non-zero whenever we are in RUN, so total_q-1 cannot underflow
  // while this term is used.
  assign on_final_line = (lines_done_q == (total_q - ONE_LINE));

  assign word_valid = in_run && (occ_q != 2'd0);
  assign word_out   = head_words[idx_q];
  assign word_last  = word_valid && at_last_word && on_final_line;

  assign xfer      = word_valid && word_ready;
  assign line_free = xfer && at_last_word;

  assign dma_rd_en = pop;
  assign busy      = in_run;
  assign done      = in_done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    lines_fetched_d = lines_fetched_q;
    lines_done_d    = lines_done_q;
    idx_d           = idx_q;
    occ_d           = occ_q;
    head_d          = head_q;
    tail_d          = tail_q;
    slot0_d         = slot0_q;
    slot1_d         = slot1_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          total_d         = line_count;
          lines_fetched_d = '0;
          lines_done_d    = '0;
          idx_d           = '0;
          occ_d           = 2'd0;
          head_d          = 1'b0;
          tail_d          = 1'b0;
          state_d         = (line_count == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // Fill side: capture the FIFO head into the tail slot.
        if (pop) begin
          if (tail_q) begin
            slot1_d = dma_rd_data;
          end else begin
            slot0_d = dma_rd_data;
          end
          tail_d          = ~tail_q;
          lines_fetched_d = lines_fetched_q + ONE_LINE;
        end

        // Drain side: step through the head line, releasing the slot after
        // its last word so the other slot is already waiting (no bubble).
        if (xfer) begin
          if (at_last_word) begin
            idx_d        = '0;
            head_d       = ~head_q;
            lines_done_d = lines_done_q + ONE_LINE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end

        // Fill and free in the same cycle leave occupancy unchanged.
        case ({pop, line_free})
          2'b10:   occ_d = occ_q + 2'd1;
          2'b01:   occ_d = occ_q - 2'd1;
          default: occ_d = occ_q;
        endcase

        if (xfer && word_last) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Reset discards buffered lines too; lines already popped from the DMA are
  // lost and software is expected to reissue the transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      total_q         <= '0;
      lines_fetched_q <= '0;
      lines_done_q    <= '0;
      idx_q           <= '0;
      occ_q           <= 2'd0;
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      slot0_q         <= '0;
      slot1_q         <= '0;
    end else begin
      state_q         <= state_d;
      total_q         <= total_d;
      lines_fetched_q <= lines_fetched_d;
      lines_done_q    <= lines_done_d;
      idx_q           <= idx_d;
      occ_q           <= occ_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      slot0_q         <= slot0_d;
      slot1_q         <= slot1_d;
    end
  end

endmodule

// File: tb/tb_dma_rd_unpacker.sv
// -----------------------------------------------------------------------------
// tb_dma_rd_unpacker
//
// Directed bench for dma_rd_unpacker. A queue of source lines stands in for the
// DMA read FIFO. Each start builds the expected word stream from the next
// line_count lines of that queue. A per-cycle compare process checks the
// outputs against a line-level model:
//   - buffer occupancy = lines popped - whole lines consumed
//   - word_valid, dma_rd_en, busy and done are derived from that occupancy
//     and from the run/done flags.
// Hand-computed literals pin the start latency, the data values and the
// pop counts.
// -----------------------------------------------------------------------------
module tb_dma_rd_unpacker;

  localparam int LW  = 512;
  localparam int WW  = 32;
  localparam int SW  = 43;
  localparam int WPL = LW / WW;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] line_count;
  logic          dma_empty;
  logic [LW-1:0] dma_rd_data;
  logic          dma_rd_en;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic          word_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dma_rd_unpacker #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .SIZE_WIDTH(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .line_count  (line_count),
    .dma_empty   (dma_empty),
    .dma_rd_data (dma_rd_data),
    .dma_rd_en   (dma_rd_en),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_last   (word_last),
    .busy        (busy),
    .done        (done)
  );

  // ---------------------------------------------------------------------------
  // Bench state: source FIFO, model, scoreboard
  // ---------------------------------------------------------------------------
  logic [LW-1:0] src_q[$];
  logic [WW-1:0] exp_q[$];
  int            gap_len = 0;
  int            hold = 0;
  int            pops = 0;
  int            words_run = 0;
  int            total_m = 0;
  bit            run_m = 0;
  bit            done_m = 0;
  bit            chk_en = 0;
  bit            stall_prev = 0;
  logic [WW-1:0] prev_word;
  logic          prev_last;
  int            stall_cnt = 0;
  int            gap_cnt = 0;
  int            ready_mode = 0;
  int            ready_step = 0;
  logic [3:0]    ready_pat = 4'b1001;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [LW-1:0] make_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < WPL; k++) l[k*WW +: WW] = base + 32'(k);
    return l;
  endfunction

  function automatic void drive_fifo();
    dma_empty   = (src_q.size() == 0) || (hold > 0);
    dma_rd_data = (src_q.size() > 0) ? src_q[0] : '0;
  endfunction

  // DMA read FIFO: show-ahead, popped whenever the DUT strobes while non-empty.
  // After each pop the FIFO can be made to look empty for gap_len cycles.
  always @(posedge clk) begin
    if (dma_rd_en && !dma_empty) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pops++;
      hold = gap_len;
    end else if (hold > 0) begin
      hold--;
    end
    #1;
    drive_fifo();
  end

  // Consumer: always ready, or a 1-0-0-1 pattern with occasional random flips.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) begin
      word_ready = 1'b1;
    end else begin
      word_ready = ready_pat[ready_step % 4] ^ ($urandom_range(0, 7) == 0);
      ready_step++;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model (sampled mid-cycle)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      int occ_m;
      occ_m = pops - (words_run / WPL);
      chk("busy", busy, run_m);
      chk("done", done, done_m);
      chk("dma_rd_en", dma_rd_en, run_m && !dma_empty && (occ_m < 2) && (pops < total_m));
      chk("word_valid", word_valid, run_m && (occ_m > 0));
      if (stall_prev) begin
        chk("stall_word_hold", word_out, prev_word);
        chk("stall_last_hold", word_last, prev_last);
      end
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          chk("word_beyond_expected", 1, 0);
        end else begin
          chk("word_out", word_out, exp_q[0]);
          chk("word_last", word_last, exp_q.size() == 1);
        end
      end else begin
        chk("word_last_idle", word_last, 0);
      end
      if (run_m && !word_valid && words_run > 0) gap_cnt++;
      stall_prev = word_valid && !word_ready;
      if (stall_prev) stall_cnt++;
      prev_word = word_out;
      prev_last = word_last;
      // Model state below reflects the edge that follows this sample.
      if (word_valid && word_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        words_run++;
        if (exp_q.size() == 0) begin
          run_m  = 0;
          done_m = 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_start(input int n);
    logic [LW-1:0] ln;
    @(posedge clk); #1;
    start      = 1'b1;
    line_count = SW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    total_m    = n;
    pops       = 0;
    words_run  = 0;
    stall_prev = 0;
    stall_cnt  = 0;
    gap_cnt    = 0;
    exp_q.delete();
    for (int l = 0; l < n; l++) begin
      ln = src_q[l];
      for (int k = 0; k < WPL; k++) exp_q.push_back(ln[k*WW +: WW]);
    end
    run_m  = (n != 0);
    done_m = (n == 0);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_done_in_budget"}, done, 1);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(make_line($urandom));
    drive_fifo();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_dma_rd_en"},  dma_rd_en,  0);
    chk({nm, "_word_valid"}, word_valid, 0);
    chk({nm, "_word_out"},   word_out,   0);
    chk({nm, "_word_last"},  word_last,  0);
    chk({nm, "_busy"},       busy,       0);
    chk({nm, "_done"},       done,       0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [LW-1:0] rs [5];
    logic [LW-1:0] ln;
    int            cnt;

    rst_n      = 1'b0;
    start      = 1'b0;
    line_count = '0;
    word_ready = 1'b1;
    src_q.push_back(make_line(32'hA000_0000));
    drive_fifo();

    // Reset then idle: FIFO non-empty, nothing may be popped.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("idle_no_pops", pops, 0);

    // Single line: words A0000000..A000000F from cycle 2, last on the 16th.
    do_start(1);
    @(negedge clk);
    chk("single_c1_valid", word_valid, 0);
    for (int k = 0; k < WPL; k++) begin
      @(negedge clk);
      chk("single_valid", word_valid, 1);
      chk("single_word", word_out, 32'hA000_0000 + 32'(k));
      chk("single_last", word_last, k == WPL - 1);
    end
    @(negedge clk);
    chk("single_done_next", done, 1);
    chk("single_valid_after", word_valid, 0);
    chk("single_pops", pops, 1);

    // Streaming: 4 lines, no gaps at line boundaries.
    load_random(4);
    do_start(4);
    @(negedge clk);
    cnt = 0;
    repeat (4 * WPL) begin
      @(negedge clk);
      if (word_valid) cnt++;
    end
    chk("stream_valid_cycles", cnt, 4 * WPL);
    @(negedge clk);
    chk("stream_done", done, 1);
    chk("stream_pops", pops, 4);

    // Backpressure: 2 lines under a stalling consumer.
    load_random(2);
    ready_mode = 1;
    do_start(2);
    wait_done(400, "bp");
    chk("bp_pops", pops, 2);
    chk("bp_stalls_seen", stall_cnt > 0, 1);
    ready_mode = 0;
    @(negedge clk);

    // DMA starvation: the FIFO goes empty long enough for the buffer to drain.
    gap_len = 20;
    load_random(3);
    do_start(3);
    wait_done(600, "starve");
    chk("starve_pops", pops, 3);
    chk("starve_gaps_seen", gap_cnt > 0, 1);
    gap_len = 0;
    hold    = 0;

    // Zero-length start from DONE: done one cycle later, no pops.
    do_start(0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("zero_pops", pops, 0);

    // Reset mid-run after 20 words of a 4-line transfer.
    for (int i = 0; i < 5; i++) begin
      rs[i] = make_line(32'hC000_0000 + 32'(i << 8));
      src_q.push_back(rs[i]);
    end
    drive_fifo();
    do_start(4);
    cnt = 0;
    while (words_run < 20 && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    chk("rst_reach_20_words", words_run >= 20, 1);
    #1;
    rst_n  = 1'b0;
    chk_en = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    exp_q.delete();
    run_m      = 0;
    done_m     = 0;
    stall_prev = 0;
    chk_en     = 1;
    repeat (2) @(negedge clk);
    // Lines 0..2 were popped before reset and are lost; line 3 comes next.
    do_start(1);
    @(negedge clk);
    @(negedge clk);
    ln = rs[3];
    chk("resume_word0", word_out, ln[WW-1:0]);
    wait_done(100, "resume");
    chk("resume_pops", pops, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
